// File: rtl/onehot_encoder.sv
// Registered 32-to-5 reversed-order one-hot encoder with a 2-entry valid/ready buffer
// and a saturating count of accepted non-one-hot words.
module onehot_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [4:0]       OUT,
    output logic             OUT_ERR,
    output logic [CNT_W-1:0] ERR_COUNT,
    input  logic             CLR_ERR
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Bit 31 is code 0; scanning upward lets the lowest code (highest bit) win.
    function automatic logic [4:0] enc_code(input logic [31:0] word);
        logic [4:0] code;
        code = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (word[i]) begin
                code = 5'(31 - i);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] word);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, word[i]};
        end
        return cnt;
    endfunction

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [4:0]       r_head_code;
    logic             r_head_err;
    logic [4:0]       r_skid_code;
    logic             r_skid_err;
    logic [CNT_W-1:0] r_err_count;

    logic             w_accept;
    logic             w_pop;
    logic [4:0]       w_code;
    logic             w_err;
    logic             w_load_head;
    logic             w_head_from_skid;
    logic             w_load_skid;

    assign w_accept = IN_VALID && r_in_ready;
    assign w_pop    = r_out_valid && OUT_READY;
    assign w_code   = enc_code(IN);
    assign w_err    = (popcount32(IN) != 6'd1);

    // Next-state and buffer-load decode
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head      = 1'b0;
        w_head_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_load_head = 1'b1;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    w_state_nxt = ST_ONE;
                    w_load_head = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_state_nxt      = ST_ONE;
                    w_head_from_skid = 1'b1;
                end else begin
                    w_state_nxt = ST_TWO;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State register; the handshake flags are registered from the next state only
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Head and skid data registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_head_code <= 5'd0;
            r_head_err  <= 1'b0;
            r_skid_code <= 5'd0;
            r_skid_err  <= 1'b0;
        end else begin
            if (w_load_head) begin
                r_head_code <= w_code;
                r_head_err  <= w_err;
            end else if (w_head_from_skid) begin
                r_head_code <= r_skid_code;
                r_head_err  <= r_skid_err;
            end else begin
                r_head_code <= r_head_code;
                r_head_err  <= r_head_err;
            end
            if (w_load_skid) begin
                r_skid_code <= w_code;
                r_skid_err  <= w_err;
            end else begin
                r_skid_code <= r_skid_code;
                r_skid_err  <= r_skid_err;
            end
        end
    end

    // Error counter counts at input time; clear beats a same-cycle increment
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err_count <= {CNT_W{1'b0}};
        end else if (CLR_ERR) begin
            r_err_count <= {CNT_W{1'b0}};
        end else if (w_accept && w_err && (r_err_count != CNT_MAX)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign OUT       = r_head_code;
    assign OUT_ERR   = r_head_err;
    assign ERR_COUNT = r_err_count;

endmodule

// File: tb/tb_onehot_encoder.sv
// Directed self-checking bench for onehot_encoder: reset, encoding, errors,
// streaming, backpressure, mid-stream reset and counter saturation.
module tb_onehot_encoder;

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [4:0]  OUT;
    logic        OUT_ERR;
    logic [7:0]  ERR_COUNT;
    logic        CLR_ERR;

    int checks = 0;
    int errors = 0;

    onehot_encoder #(.CNT_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN(IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT(OUT), .OUT_ERR(OUT_ERR),
        .ERR_COUNT(ERR_COUNT), .CLR_ERR(CLR_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; IN_VALID = 1'b0; IN = 32'd0; OUT_READY = 1'b0; CLR_ERR = 1'b0;
        #2;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", IN_READY); end
        checks++; if (OUT !== 5'd0 || OUT_ERR !== 1'b0) begin errors++; $display("FAIL reset_out: got %0d/%b expected 0/0", OUT, OUT_ERR); end
        checks++; if (ERR_COUNT !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", ERR_COUNT); end
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_single();
        OUT_READY = 1'b1; IN_VALID = 1'b1; IN = 32'h8000_0000;
        tick();
        IN_VALID = 1'b0;
        checks++; if (OUT_VALID !== 1'b1 || OUT !== 5'd0 || OUT_ERR !== 1'b0) begin errors++; $display("FAIL single_msb: got v=%b code=%0d err=%b expected v=1 code=0 err=0", OUT_VALID, OUT, OUT_ERR); end
        tick();
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL single_msb_drain: got %b expected 0", OUT_VALID); end
        IN_VALID = 1'b1; IN = 32'h0000_0001;
        tick();
        IN_VALID = 1'b0;
        checks++; if (OUT_VALID !== 1'b1 || OUT !== 5'd31 || OUT_ERR !== 1'b0) begin errors++; $display("FAIL single_lsb: got v=%b code=%0d err=%b expected v=1 code=31 err=0", OUT_VALID, OUT, OUT_ERR); end
        checks++; if (ERR_COUNT !== 8'd0) begin errors++; $display("FAIL single_err_count: got %0d expected 0", ERR_COUNT); end
        tick();
    endtask

    task automatic test_errors();
        OUT_READY = 1'b1; IN_VALID = 1'b1; IN = 32'h0000_0300;
        tick();
        IN_VALID = 1'b0;
        checks++; if (OUT !== 5'd22 || OUT_ERR !== 1'b1) begin errors++; $display("FAIL err_two_bits: got code=%0d err=%b expected code=22 err=1", OUT, OUT_ERR); end
        checks++; if (ERR_COUNT !== 8'd1) begin errors++; $display("FAIL err_count_1: got %0d expected 1", ERR_COUNT); end
        tick();
        IN_VALID = 1'b1; IN = 32'h0000_0000;
        tick();
        IN_VALID = 1'b0;
        checks++; if (OUT !== 5'd0 || OUT_ERR !== 1'b1) begin errors++; $display("FAIL err_zero: got code=%0d err=%b expected code=0 err=1", OUT, OUT_ERR); end
        checks++; if (ERR_COUNT !== 8'd2) begin errors++; $display("FAIL err_count_2: got %0d expected 2", ERR_COUNT); end
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] msb;
        msb = 32'h8000_0000;
        OUT_READY = 1'b1; IN_VALID = 1'b1;
        for (int i = 0; i < 32; i++) begin
            IN = msb >> i;
            tick();
            checks++; if (OUT_VALID !== 1'b1 || OUT !== 5'(i) || OUT_ERR !== 1'b0 || IN_READY !== 1'b1) begin
                errors++; $display("FAIL stream_%0d: got v=%b code=%0d err=%b rdy=%b expected v=1 code=%0d err=0 rdy=1", i, OUT_VALID, OUT, OUT_ERR, IN_READY, i);
            end
        end
        IN_VALID = 1'b0;
        tick();
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b expected 0", OUT_VALID); end
        checks++; if (ERR_COUNT !== 8'd2) begin errors++; $display("FAIL stream_err_count: got %0d expected 2", ERR_COUNT); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] msb;
        msb = 32'h8000_0000;
        OUT_READY = 1'b0; IN_VALID = 1'b1; IN = msb >> 5;
        tick();
        checks++; if (IN_READY !== 1'b1 || OUT !== 5'd5) begin errors++; $display("FAIL bp_first: got rdy=%b code=%0d expected rdy=1 code=5", IN_READY, OUT); end
        IN = msb >> 6;
        tick();
        checks++; if (IN_READY !== 1'b0 || OUT !== 5'd5) begin errors++; $display("FAIL bp_full: got rdy=%b code=%0d expected rdy=0 code=5", IN_READY, OUT); end
        IN = msb >> 7;
        tick();
        tick();
        checks++; if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || OUT !== 5'd5) begin errors++; $display("FAIL bp_hold: got rdy=%b v=%b code=%0d expected rdy=0 v=1 code=5", IN_READY, OUT_VALID, OUT); end
        OUT_READY = 1'b1;
        tick();
        checks++; if (OUT !== 5'd6 || IN_READY !== 1'b1) begin errors++; $display("FAIL bp_out6: got code=%0d rdy=%b expected code=6 rdy=1", OUT, IN_READY); end
        tick();
        IN_VALID = 1'b0;
        checks++; if (OUT !== 5'd7 || OUT_VALID !== 1'b1) begin errors++; $display("FAIL bp_out7: got code=%0d v=%b expected code=7 v=1", OUT, OUT_VALID); end
        tick();
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0 (duplicate word)", OUT_VALID); end
    endtask

    task automatic test_reset_mid();
        OUT_READY = 1'b0; IN_VALID = 1'b1; IN = 32'h1000_0000;
        tick();
        IN = 32'h0000_0000;
        tick();
        IN_VALID = 1'b0;
        checks++; if (IN_READY !== 1'b0 || ERR_COUNT !== 8'd3) begin errors++; $display("FAIL rst_mid_pre: got rdy=%b cnt=%0d expected rdy=0 cnt=3", IN_READY, ERR_COUNT); end
        #2;
        RST = 1'b1;
        #1;
        checks++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin errors++; $display("FAIL rst_mid_flags: got v=%b rdy=%b expected v=0 rdy=1", OUT_VALID, IN_READY); end
        checks++; if (OUT !== 5'd0 || OUT_ERR !== 1'b0 || ERR_COUNT !== 8'd0) begin errors++; $display("FAIL rst_mid_data: got code=%0d err=%b cnt=%0d expected 0/0/0", OUT, OUT_ERR, ERR_COUNT); end
        #2;
        RST = 1'b0;
        OUT_READY = 1'b1;
        tick();
        tick();
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_mid_stale: got %b expected 0", OUT_VALID); end
    endtask

    task automatic test_saturation();
        OUT_READY = 1'b1; IN_VALID = 1'b1; IN = 32'h0000_0000;
        repeat (254) tick();
        checks++; if (ERR_COUNT !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", ERR_COUNT); end
        repeat (46) tick();
        checks++; if (ERR_COUNT !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", ERR_COUNT); end
        CLR_ERR = 1'b1;
        tick();
        CLR_ERR = 1'b0;
        checks++; if (ERR_COUNT !== 8'd0) begin errors++; $display("FAIL sat_clear: got %0d expected 0", ERR_COUNT); end
        tick();
        IN_VALID = 1'b0;
        checks++; if (ERR_COUNT !== 8'd1) begin errors++; $display("FAIL sat_after_clear: got %0d expected 1", ERR_COUNT); end
        tick();
        checks++; if (ERR_COUNT !== 8'd1) begin errors++; $display("FAIL sat_idle_hold: got %0d expected 1", ERR_COUNT); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_errors();
        test_stream();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
